// File: rtl/pspin_cfg_pkg.sv
// rtl/pspin_cfg_pkg.sv - PsPIN command/response types and command interface IDs
package pspin_cfg_pkg;

  localparam int unsigned NUM_CMD_INTERFACES  = 3;
  localparam int unsigned CMD_HOSTDIRECT_ID   = 0;
  localparam int unsigned CMD_NIC_OUTBOUND_ID = 1;
  localparam int unsigned CMD_EDMA_ID         = 2;

  typedef logic [1:0] pspin_cmd_intf_id_t;

  typedef struct packed {
    logic [7:0]         cmd_id;
    pspin_cmd_intf_id_t intf_id;
    logic [31:0]        addr;
    logic [15:0]        length;
  } pspin_cmd_t;

  typedef struct packed {
    logic [7:0]         cmd_id;
    pspin_cmd_intf_id_t intf_id;
    logic [15:0]        status;
  } pspin_cmd_resp_t;

endpackage

// File: rtl/pspin_cmd_router_pkg.sv
// rtl/pspin_cmd_router_pkg.sv - flattened port widths shared by the command router files
package pspin_cmd_router_pkg;

  localparam int unsigned CMD_W  = $bits(pspin_cfg_pkg::pspin_cmd_t);
  localparam int unsigned RESP_W = $bits(pspin_cfg_pkg::pspin_cmd_resp_t);

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - in-order FIFO with optional fall-through, async active-low reset
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LAST     = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  dtype                  mem_q [DEPTH];
  logic                  do_push, do_pop, bypass, unused_testmode;

  assign unused_testmode = testmode_i;
  assign full_o  = (cnt_q == FULL_CNT);
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_q];
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if (!(bypass && do_pop)) begin
      if (do_push) begin
        wr_d  = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        cnt_d = cnt_d + 1'b1;
      end
      if (do_pop) begin
        rd_d  = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        cnt_d = cnt_d - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i && !(bypass && do_pop)) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pspin_cmd_router_resp_merge.sv
// rtl/pspin_cmd_router_resp_merge.sv - pspin_cmd_resp_merge: round-robin merge of completions
// into one registered response stream
module pspin_cmd_resp_merge
  import pspin_cmd_router_pkg::*;
#(
  parameter int unsigned NUM_INTF = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_INTF-1:0]        resp_valid_i,
  output logic [NUM_INTF-1:0]        resp_ready_o,
  input  logic [NUM_INTF*RESP_W-1:0] resp_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [RESP_W-1:0]          resp_o
);

  localparam int unsigned PW = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;

  logic [PW-1:0]     ptr_q, ptr_d, gnt;
  logic              valid_q, valid_d, can_load, found;
  logic [RESP_W-1:0] data_q, data_d;

  function automatic logic [PW-1:0] wrap_idx(input int unsigned v);
    return PW'((v >= NUM_INTF) ? v - NUM_INTF : v);
  endfunction

  assign can_load = !rst_i && (!valid_q || resp_ready_i);

  // First requester at or after the pointer, searching circularly
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    for (int unsigned k = 0; k < NUM_INTF; k++) begin
      if (!found && resp_valid_i[wrap_idx(32'(ptr_q) + k)]) begin
        found = 1'b1;
        gnt   = wrap_idx(32'(ptr_q) + k);
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned g = 0; g < NUM_INTF; g++) begin
      resp_ready_o[g] = can_load && found && (gnt == PW'(g));
    end
    if (can_load) begin
      valid_d = found;
      if (found) begin
        data_d = resp_i[32'(gnt) * RESP_W +: RESP_W];
        ptr_d  = (gnt == PW'(NUM_INTF - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign resp_valid_o = valid_q;
  assign resp_o       = data_q;

endmodule

// File: rtl/pspin_cmd_router.sv
// rtl/pspin_cmd_router.sv - routes HPU commands to host/NIC/DMA interfaces by intf_id with
// per-interface credits, and merges their completions back into one stream
module pspin_cmd_router
  import pspin_cfg_pkg::*;
  import pspin_cmd_router_pkg::*;
#(
  parameter int unsigned NUM_INTF        = pspin_cfg_pkg::NUM_CMD_INTERFACES,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [CMD_W-1:0]           cmd_i,
  output logic [NUM_INTF-1:0]        intf_cmd_valid_o,
  input  logic [NUM_INTF-1:0]        intf_cmd_ready_i,
  output logic [NUM_INTF*CMD_W-1:0]  intf_cmd_o,
  input  logic [NUM_INTF-1:0]        intf_resp_valid_i,
  output logic [NUM_INTF-1:0]        intf_resp_ready_o,
  input  logic [NUM_INTF*RESP_W-1:0] intf_resp_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [RESP_W-1:0]          resp_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int unsigned OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FIFO_UW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTSTANDING);

  pspin_cmd_t          cmd;
  pspin_cmd_intf_id_t  tgt;
  logic                bad_id, cmd_hs;
  logic [NUM_INTF-1:0] sel, can_accept, push, full, empty, resp_hs;
  logic [OW-1:0]       outst_q [NUM_INTF];
  logic [OW-1:0]       outst_d [NUM_INTF];
  logic                err_q, err_d, idle_q, idle_d;

  assign cmd    = pspin_cmd_t'(cmd_i);
  assign tgt    = cmd.intf_id;
  assign bad_id = (32'(tgt) >= NUM_INTF);

  always_comb begin
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      sel[i]        = (32'(tgt) == i);
      can_accept[i] = !full[i] && (outst_q[i] < OUTST_MAX);
    end
  end

  // Unknown targets are always taken so a bad command cannot stall the cluster
  assign cmd_ready_o = !rst_i && (bad_id || |(sel & can_accept));
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign push        = sel & {NUM_INTF{cmd_hs}};
  assign resp_hs     = intf_resp_valid_i & intf_resp_ready_o;

  for (genvar i = 0; i < NUM_INTF; i++) begin : g_intf
    logic [FIFO_UW-1:0] usage_unused;
    pspin_cmd_t         fifo_out;

    fifo_v3 #(
      .FALL_THROUGH(1'b0),
      .DATA_WIDTH  (CMD_W),
      .DEPTH       (FIFO_DEPTH),
      .dtype       (pspin_cmd_t)
    ) i_cmd_fifo (
      .clk_i     (clk_i),
      .rst_ni    (~rst_i),
      .flush_i   (1'b0),
      .testmode_i(1'b0),
      .full_o    (full[i]),
      .empty_o   (empty[i]),
      .usage_o   (usage_unused),
      .data_i    (cmd),
      .push_i    (push[i]),
      .data_o    (fifo_out),
      .pop_i     (intf_cmd_valid_o[i] && intf_cmd_ready_i[i])
    );

    assign intf_cmd_valid_o[i]            = ~empty[i];
    assign intf_cmd_o[i*CMD_W +: CMD_W] = fifo_out;
  end

  // A completion with nothing outstanding is still forwarded; the counter saturates at zero
  always_comb begin
    err_d  = cmd_hs && bad_id;
    idle_d = &empty && !resp_valid_o;
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      outst_d[i] = outst_q[i];
      idle_d     = idle_d && (outst_q[i] == '0);
      if (resp_hs[i] && (outst_q[i] == '0)) err_d = 1'b1;
      if (push[i] && !resp_hs[i]) begin
        outst_d[i] = outst_q[i] + OW'(1);
      end else if (!push[i] && resp_hs[i] && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - OW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_INTF); i++) outst_q[i] <= '0;
      err_q  <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(NUM_INTF); i++) outst_q[i] <= outst_d[i];
      err_q  <= err_d;
      idle_q <= idle_d;
    end
  end

  assign err_o  = err_q;
  assign idle_o = idle_q;

  pspin_cmd_resp_merge #(
    .NUM_INTF(NUM_INTF)
  ) i_resp_merge (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .resp_valid_i(intf_resp_valid_i),
    .resp_ready_o(intf_resp_ready_o),
    .resp_i      (intf_resp_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_o      (resp_o)
  );

endmodule

// File: tb/tb_pspin_cmd_router.sv
// tb/tb_pspin_cmd_router.sv - randomized scoreboard bench for pspin_cmd_router
module tb_pspin_cmd_router;
  import pspin_cfg_pkg::*;

  localparam int N    = 3;
  localparam int FD   = 2;
  localparam int MAXO = 16;
  localparam int CW   = $bits(pspin_cmd_t);
  localparam int RW   = $bits(pspin_cmd_resp_t);

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid_i, cmd_ready_o;
  logic [CW-1:0]   cmd_i;
  logic [N-1:0]    intf_cmd_valid_o, intf_cmd_ready_i;
  logic [N*CW-1:0] intf_cmd_o;
  logic [N-1:0]    intf_resp_valid_i, intf_resp_ready_o;
  logic [N*RW-1:0] intf_resp_i;
  logic            resp_valid_o, resp_ready_i;
  logic [RW-1:0]   resp_o;
  logic            idle_o, err_o;

  always #5 clk = ~clk;

  pspin_cmd_router #(
    .NUM_INTF(N), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
    .intf_cmd_valid_o(intf_cmd_valid_o), .intf_cmd_ready_i(intf_cmd_ready_i), .intf_cmd_o(intf_cmd_o),
    .intf_resp_valid_i(intf_resp_valid_i), .intf_resp_ready_o(intf_resp_ready_o), .intf_resp_i(intf_resp_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct {
    int            intf;
    logic [CW-1:0] data;
  } cmd_exp_t;

  int vectors = 0, miscompares = 0;
  cmd_exp_t      exp_cmd_q [$];
  logic [RW-1:0] exp_resp_q [$];

  // Reference model: occupancy / credit counts and the single response slot
  int            fifo_cnt_m [N];
  int            outst_m [N];
  bit            resp_v_m, err_m, idle_m;
  logic [RW-1:0] resp_m;
  int            ptr_m;
  logic [RW-1:0] resp_data [N];
  logic [N-1:0]  rsp_taken;
  int            acc_count, err_seen;
  int            gnt_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (intf_cmd_valid_o[i] && intf_cmd_ready_i[i]) begin
        int idx;
        idx = -1;
        for (int j = 0; j < exp_cmd_q.size(); j++)
          if (idx < 0 && exp_cmd_q[j].intf == i) idx = j;
        if (idx < 0) chk($sformatf("cmd_unexpected[%0d]", i), 1, 0);
        else begin
          chk($sformatf("intf_cmd_o[%0d]", i), intf_cmd_o[i*CW +: CW], exp_cmd_q[idx].data);
          exp_cmd_q.delete(idx);
        end
      end
    end
    if (resp_valid_o && resp_ready_i) begin
      if (exp_resp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else chk("resp_o", resp_o, exp_resp_q.pop_front());
    end
  end

  task automatic drive_cmd(input bit v, input int id);
    pspin_cmd_t c;
    c.cmd_id  = 8'($urandom);
    c.intf_id = 2'(id);
    c.addr    = $urandom;
    c.length  = 16'($urandom);
    cmd_i       = c;
    cmd_valid_i = v;
  endtask

  task automatic refresh_resp(input logic [N-1:0] want);
    for (int i = 0; i < N; i++) begin
      if (!(intf_resp_valid_i[i] && !rsp_taken[i])) begin
        intf_resp_valid_i[i] = want[i];
        if (want[i]) begin
          pspin_cmd_resp_t r;
          r.cmd_id  = 8'($urandom);
          r.intf_id = 2'(i);
          r.status  = 16'($urandom);
          resp_data[i] = r;
        end
      end
      intf_resp_i[i*RW +: RW] = resp_data[i];
    end
    rsp_taken = '0;
  endtask

  task automatic step();
    pspin_cmd_t   c;
    int           t, g;
    bit           exp_rdy, acc, can_load, found, idle_n, err_n, push, pop;
    logic [N-1:0] exp_rr;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("intf_cmd_valid[%0d]", i), intf_cmd_valid_o[i], fifo_cnt_m[i] > 0);
    chk("resp_valid", resp_valid_o, resp_v_m);
    if (resp_v_m) chk("resp_hold", resp_o, resp_m);
    chk("err", err_o, err_m);
    chk("idle", idle_o, idle_m);
    if (err_o) err_seen++;
    c = cmd_i;
    t = int'(c.intf_id);
    exp_rdy = (t >= N) ? 1'b1 : (fifo_cnt_m[t] < FD && outst_m[t] < MAXO);
    chk("cmd_ready", cmd_ready_o, exp_rdy);
    acc = cmd_valid_i && exp_rdy;
    if (acc) acc_count++;
    can_load = !resp_v_m || resp_ready_i;
    found = 0;
    g = 0;
    for (int k = 0; k < N; k++)
      if (!found && intf_resp_valid_i[(ptr_m + k) % N]) begin
        found = 1;
        g = (ptr_m + k) % N;
      end
    exp_rr = (can_load && found) ? N'(1 << g) : '0;
    chk("intf_resp_ready", intf_resp_ready_o, exp_rr);
    for (int i = 0; i < N; i++)
      if (intf_resp_ready_o[i]) gnt_log.push_back(i);

    idle_n = !resp_v_m;
    err_n  = acc && (t >= N);
    for (int i = 0; i < N; i++) begin
      if (fifo_cnt_m[i] != 0 || outst_m[i] != 0) idle_n = 0;
      push = acc && (t == i);
      pop  = fifo_cnt_m[i] > 0 && intf_cmd_ready_i[i];
      if (push) exp_cmd_q.push_back('{intf: i, data: cmd_i});
      fifo_cnt_m[i] += int'(push) - int'(pop);
      if (exp_rr[i] && outst_m[i] == 0) err_n = 1;
      if (push && !exp_rr[i]) outst_m[i]++;
      else if (exp_rr[i] && !push && outst_m[i] > 0) outst_m[i]--;
    end
    if (can_load) begin
      resp_v_m = found;
      if (found) begin
        resp_m = resp_data[g];
        exp_resp_q.push_back(resp_data[g]);
        ptr_m = (g + 1) % N;
      end
    end
    err_m     = err_n;
    idle_m    = idle_n;
    rsp_taken = exp_rr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid_i       = 1'b0;
    cmd_i             = '0;
    intf_cmd_ready_i  = '1;
    intf_resp_valid_i = '0;
    intf_resp_i       = '0;
    resp_ready_i      = 1'b1;
    rst               = 1'b1;
    for (int i = 0; i < N; i++) begin
      fifo_cnt_m[i] = 0;
      outst_m[i]    = 0;
      resp_data[i]  = '0;
    end
    resp_v_m  = 0;
    resp_m    = '0;
    err_m     = 0;
    idle_m    = 1;
    ptr_m     = 0;
    rsp_taken = '0;
    exp_cmd_q.delete();
    exp_resp_q.delete();
    gnt_log.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    cmd_valid_i       = 1'b1;
    cmd_i             = '0;
    intf_cmd_ready_i  = '1;
    intf_resp_valid_i = '1;
    intf_resp_i       = '1;
    resp_ready_i      = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_intf_cmd_valid", intf_cmd_valid_o, 0);
    chk("rst_intf_resp_ready", intf_resp_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_intf_cmd_o", intf_cmd_o[63:0], 0);
    chk("rst_resp_o", resp_o, 0);

    // Routing
    do_reset();
    for (int id = 0; id < N; id++) begin
      drive_cmd(1, id);
      step();
    end
    drive_cmd(0, 0);
    repeat (3) step();

    // Credit limit on interface 1
    do_reset();
    acc_count = 0;
    for (int k = 0; k < 17; k++) begin
      drive_cmd(1, CMD_NIC_OUTBOUND_ID);
      step();
    end
    chk("credit_accepts", acc_count, 16);
    refresh_resp(3'b010);
    step();
    refresh_resp(3'b000);
    repeat (3) step();

    // Backpressure on interface 2
    do_reset();
    intf_cmd_ready_i = 3'b011;
    acc_count = 0;
    for (int k = 0; k < 3; k++) begin
      drive_cmd(1, CMD_EDMA_ID);
      step();
    end
    chk("backpressure_accepts", acc_count, 2);
    drive_cmd(0, 0);
    step();
    intf_cmd_ready_i = '1;
    repeat (3) step();

    // Errors: bad intf_id, then a completion with nothing outstanding
    do_reset();
    err_seen = 0;
    drive_cmd(1, 3);
    step();
    drive_cmd(0, 0);
    repeat (2) step();
    chk("err_pulses_bad_id", err_seen, 1);
    refresh_resp(3'b001);
    step();
    refresh_resp(3'b000);
    repeat (2) step();
    chk("err_pulses_orphan_resp", err_seen, 2);
    drive_cmd(1, CMD_HOSTDIRECT_ID);
    step();
    drive_cmd(0, 0);
    step();
    refresh_resp(3'b001);
    step();
    refresh_resp(3'b000);
    repeat (2) step();
    chk("err_pulses_after_saturate", err_seen, 2);

    // Round-robin fairness with a stall
    do_reset();
    for (int k = 0; k < 15; k++) begin
      resp_ready_i = !(k >= 6 && k < 9);
      refresh_resp(3'b111);
      step();
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_grant[%0d]", k), (gnt_log.size() > k) ? gnt_log[k] : -1, k % N);
    refresh_resp(3'b000);
    resp_ready_i = 1'b1;
    repeat (4) step();

    // Reset with queued commands and a pending response
    do_reset();
    intf_cmd_ready_i = 3'b000;
    for (int k = 0; k < 2; k++) begin
      drive_cmd(1, 0);
      step();
    end
    drive_cmd(0, 0);
    resp_ready_i = 1'b0;
    refresh_resp(3'b010);
    step();
    refresh_resp(3'b000);
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_intf_cmd_valid", intf_cmd_valid_o, 0);
    chk("midrst_resp_valid", resp_valid_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 0);
    do_reset();
    step();
    chk("midrst_idle_after", idle_o, 1);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] want;
      drive_cmd($urandom_range(0, 9) < 7, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2));
      intf_cmd_ready_i = N'($urandom);
      resp_ready_i     = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N; i++) want[i] = $urandom_range(0, 9) < 3;
      refresh_resp(want);
      step();
    end

    // Drain
    drive_cmd(0, 0);
    intf_cmd_ready_i = '1;
    resp_ready_i     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      refresh_resp(3'b000);
      step();
    end
    chk("drain_cmd_scoreboard", exp_cmd_q.size(), 0);
    chk("drain_resp_scoreboard", exp_resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pspin_cmd_router.md
# pspin_cmd_router

Routes HPU-issued `pspin_cmd_t` commands to the command interfaces: host-direct (ID 0), NIC outbound (ID 1) and soc-level DMA (ID 2). The route is selected by `intf_id`. On the return path it merges the per-interface `pspin_cmd_resp_t` completions into one response stream back to the clusters. It sits between the cluster command arbitration and the interface engines. It applies per-interface credit limits, tracks outstanding commands and reports idle.

## Interface
Parameters:
- `NUM_INTF`, default `pspin_cfg_pkg::NUM_CMD_INTERFACES` (3): number of downstream command interfaces.
- `FIFO_DEPTH`, default 2: depth of each per-interface command FIFO, ≥1.
- `MAX_OUTSTANDING`, default 16: maximum number of commands per interface that are accepted and not yet completed.

Ports:
- `clk_i` input, 1: the single clock.
- `rst_i` input, 1: reset, asynchronous, active-high.
- `cmd_valid_i` / `cmd_ready_o`, in / out, 1 each: inbound command handshake.
- `cmd_i` input, `$bits(pspin_cmd_t)`: inbound command.
- `intf_cmd_valid_o` / `intf_cmd_ready_i`, out / in, `NUM_INTF` each: per-interface command handshake.
- `intf_cmd_o` output, `NUM_INTF` × `$bits(pspin_cmd_t)`: per-interface command.
- `intf_resp_valid_i` / `intf_resp_ready_o`, in / out, `NUM_INTF` each: per-interface completion handshake.
- `intf_resp_i` input, `NUM_INTF` × `$bits(pspin_cmd_resp_t)`: per-interface completion.
- `resp_valid_o` / `resp_ready_i`, out / in, 1 each: merged completion handshake.
- `resp_o` output, `$bits(pspin_cmd_resp_t)`: merged completion.
- `idle_o` output, 1: all FIFOs empty, all counters zero and the response register empty.
- `err_o` output, 1: one-cycle pulse on a protocol error.

## Operation
- **Route.** Let `t = cmd_i.intf_id`. The command is pushed into FIFO[t] on `cmd_valid_i && cmd_ready_o`.
- **cmd_ready_o.**
  - For a valid `t`: `cmd_ready_o = !full[t] && (outst[t] < MAX_OUTSTANDING)`.
  - For `t ≥ NUM_INTF`: `cmd_ready_o = 1`.
  - `cmd_ready_o` depends combinationally on `cmd_i`. `cmd_valid_i` must not depend on `cmd_ready_o`.
- **Bad intf_id.** A command with `t ≥ NUM_INTF` is accepted and dropped, with no FIFO push and no counter change. `err_o` pulses in the following cycle.
- **Command FIFOs.**
  - One FIFO per interface, non-fall-through, in-order.
  - `intf_cmd_valid_o[i] = !empty[i]`.
  - The FIFO pops on `intf_cmd_valid_o[i] && intf_cmd_ready_i[i]`.
  - Push and pop in the same cycle on a full FIFO is not allowed; `cmd_ready_o` uses the registered `full`.
- **Outstanding counters.**
  - `outst[i]` is `$clog2(MAX_OUTSTANDING+1)` bits wide.
  - Incremented on push to FIFO[i]; decremented on the `intf_resp` handshake of interface i.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - A response handshake while `outst[i] == 0` is still forwarded. The counter stays at 0 (saturates) and `err_o` pulses in the next cycle.
- **Response merge.**
  - Round-robin arbitration over `intf_resp_valid_i` feeds a single output register (`resp_valid_o` / `resp_o`).
  - The register loads when it is empty or being drained in the same cycle (`resp_ready_i && resp_valid_o`).
  - `intf_resp_ready_o[g]` is asserted only for the granted `g`, and only when the register can load.
  - After a grant to `g`, the RR pointer moves to `g+1` mod `NUM_INTF`. The pointer holds when no grant is made.
  - Responses pass through unmodified.
- **Output stability.** `resp_valid_o` and `resp_o` are held stable until `resp_ready_i`. The same holds for `intf_cmd_valid_o` and `intf_cmd_o` until `intf_cmd_ready_i`.

## Timing
- **Reset values.**
  - 0: `cmd_ready_o` (registered parts), `intf_cmd_valid_o`, `intf_resp_ready_o`, `resp_valid_o`, `err_o`.
  - 1: `idle_o`.
  - Cleared: all FIFOs, counters and the RR pointer (pointer resets to 0).
  - `intf_cmd_o` and `resp_o` are 0.
- **Command latency.** Accept at cycle N gives `intf_cmd_valid_o` at N+1. Throughput is 1 command per cycle per interface.
- **Response latency.** Handshake at cycle N gives `resp_valid_o` at N+1. Throughput is 1 response per cycle under constant `resp_ready_i`.
- **idle_o.** Registered; reflects state as of the previous cycle edge.
- **Reset mid-operation.** In-flight commands and responses are discarded. No handshake completes in the reset cycle.

## Structure
- `pspin_cmd_t`, `pspin_cmd_resp_t`, `NUM_CMD_INTERFACES` and the `CMD_*_ID` constants come from `pspin_cfg_pkg`. No new package types.
- The FIFOs are `fifo_v3` from common_cells with `FALL_THROUGH=0` and `rst_ni = ~rst_i`.
- One sub-module, `pspin_cmd_resp_merge`: the RR arbiter plus the output register, parameterised on `NUM_INTF`.

## Test plan
- **Routing.** Send one command each with `intf_id` 0, 1, 2, all readies high. Each appears only on its matching `intf_cmd_o` one cycle later, bit-exact; `outst` = {1,1,1}; `idle_o` = 0.
- **Credit.** Send 17 commands to `intf_id` 1 with `intf_resp` silent. 16 are accepted and `cmd_ready_o` = 0 on the 17th. One response on interface 1 re-raises `cmd_ready_o` the next cycle.
- **Backpressure.** Hold `intf_cmd_ready_i[2]` = 0 and send 3 commands to ID 2. Two are accepted and FIFO[2] is full. Releasing ready drains them in order.
- **RR fairness.** Hold all three `intf_resp_valid_i` high continuously. Grants go in order 0, 1, 2, 0, …. Holding `resp_ready_i` low for 3 cycles holds `resp_o` stable and asserts no `intf_resp_ready_o`.
- **Errors.** A command with `intf_id` = 3 is accepted and not forwarded, and `err_o` pulses once. A response on interface 0 with `outst[0]` = 0 is forwarded, `err_o` pulses, and `outst[0]` stays 0.
- **Reset.** Asserting `rst_i` with 2 queued commands and a pending response clears all valids asynchronously, with `idle_o` = 1 after release.
